mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// per-operation latencies and the controller state type.
package mdu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  // Operation codes; 9-15 are unused and behave as NONE.
  localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;

  // Number of cycles Busy stays high for each operation class.
  localparam int unsigned MULT_LATENCY = 5;
  localparam int unsigned DIV_LATENCY  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// The result is computed in the Start cycle and held in temp registers;
// Busy then models the multi-cycle latency, and HI/LO are committed on
// the edge that ends BUSY.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset
//   S1, S2    - operands (rs, rt)
//   MDUOp     - operation code (mdu_pkg)
//   Start     - launch pulse for MULT/MULTU/DIV/DIVU
//   Busy      - registered, high while an operation is in flight
//   HI, LO    - architectural result registers
//   MDUResult - combinational MFHI/MFLO read data
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] S1,
  input  logic [31:0] S2,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUResult
);
  import mdu_pkg::*;

  mdu_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_no_commit;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_hi_tmp;
  logic [DATA_W-1:0]   r_lo_tmp;

  logic                w_is_mul;
  logic                w_is_div;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic [DATA_W-1:0]   w_div_b;
  logic signed [63:0]  w_s1_sx;
  logic signed [63:0]  w_s2_sx;
  logic signed [63:0]  w_prod_s;
  logic [63:0]         w_prod_u;
  logic signed [31:0]  w_sq;
  logic signed [31:0]  w_sr;
  logic [DATA_W-1:0]   w_uq;
  logic [DATA_W-1:0]   w_ur;
  logic [DATA_W-1:0]   w_hi_next;
  logic [DATA_W-1:0]   w_lo_next;
  logic [CNT_W-1:0]    w_cnt_load;

  assign w_is_mul = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
  assign w_is_div = (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU);

  // Divisor is forced to 1 for /0 (result discarded) and for the signed
  // INT_MIN / -1 overflow, which then yields quotient INT_MIN, remainder 0.
  assign w_div_zero = (S2 == 32'd0);
  assign w_div_ovf  = (MDUOp == MDU_DIV) && (S1 == 32'h8000_0000) &&
                      (S2 == 32'hFFFF_FFFF);
  assign w_div_b    = (w_div_zero || w_div_ovf) ? 32'd1 : S2;

  assign w_s1_sx  = {{32{S1[31]}}, S1};
  assign w_s2_sx  = {{32{S2[31]}}, S2};
  assign w_prod_s = w_s1_sx * w_s2_sx;
  assign w_prod_u = {32'd0, S1} * {32'd0, S2};

  // Signed operators truncate toward zero; remainder follows the dividend.
  assign w_sq = $signed(S1) / $signed(w_div_b);
  assign w_sr = $signed(S1) % $signed(w_div_b);
  assign w_uq = S1 / w_div_b;
  assign w_ur = S1 % w_div_b;

  // Result and latency selection for the launching operation.
  always_comb begin
    w_hi_next  = '0;
    w_lo_next  = '0;
    w_cnt_load = CNT_W'(MULT_LATENCY - 1);
    unique case (MDUOp)
      MDU_MULT:  begin w_hi_next = w_prod_s[63:32]; w_lo_next = w_prod_s[31:0]; end
      MDU_MULTU: begin w_hi_next = w_prod_u[63:32]; w_lo_next = w_prod_u[31:0]; end
      MDU_DIV: begin
        w_hi_next  = w_sr;
        w_lo_next  = w_sq;
        w_cnt_load = CNT_W'(DIV_LATENCY - 1);
      end
      MDU_DIVU: begin
        w_hi_next  = w_ur;
        w_lo_next  = w_uq;
        w_cnt_load = CNT_W'(DIV_LATENCY - 1);
      end
      default: ;
    endcase
  end

  // Controller, temps and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= MDU_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_no_commit <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_hi_tmp    <= '0;
      r_lo_tmp    <= '0;
    end else begin
      unique case (r_state)
        MDU_IDLE: begin
          if (Start && (w_is_mul || w_is_div)) begin
            r_state     <= MDU_BUSY;
            r_busy      <= 1'b1;
            r_cnt       <= w_cnt_load;
            r_hi_tmp    <= w_hi_next;
            r_lo_tmp    <= w_lo_next;
            r_no_commit <= w_is_div && w_div_zero;
          end
          if (MDUOp == MDU_MTHI) r_hi <= S1;
          if (MDUOp == MDU_MTLO) r_lo <= S1;
        end
        MDU_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= MDU_IDLE;
            r_busy  <= 1'b0;
            if (!r_no_commit) begin
              r_hi <= r_hi_tmp;
              r_lo <= r_lo_tmp;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Read port is independent of Busy.
  always_comb begin
    MDUResult = '0;
    if (MDUOp == MDU_MFHI)      MDUResult = r_hi;
    else if (MDUOp == MDU_MFLO) MDUResult = r_lo;
  end

endmodule
